// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
// - Default 640x480@60 Hz timing values (pixels / lines), with the line and
//   frame totals and the derived sync start/end positions.
// - Coordinate width (10 bits covers 0..799 and 0..524).
// - vga_ctrl_t: the {hsync, vsync, blank_n} bundle driven to the DAC, its
//   reset value, and a decode helper that works from parameterised bounds.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    // Pixel divider width; CLK_DIV is limited to 1..8 so 3 bits hold 0..7.
    localparam int DIV_W   = 3;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef struct packed {
        logic hsync;    // active low
        logic vsync;    // active low
        logic blank_n;  // high inside the visible area
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_RESET = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

    // Decode sync/blank from the raw counters. Sync windows are inclusive.
    function automatic vga_ctrl_t decode_ctrl(
        input logic [COORD_W-1:0] h,
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] h_active,
        input logic [COORD_W-1:0] h_sync_start,
        input logic [COORD_W-1:0] h_sync_end,
        input logic [COORD_W-1:0] v_active,
        input logic [COORD_W-1:0] v_sync_start,
        input logic [COORD_W-1:0] v_sync_end
    );
        vga_ctrl_t c;
        c.hsync   = !((h >= h_sync_start) && (h <= h_sync_end));
        c.vsync   = !((v >= v_sync_start) && (v <= v_sync_end));
        c.blank_n = (h < h_active) && (v < v_active);
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line
// Enable-gated shift register used to hold sync/blank back so they line up
// with pixel data that has passed through mapping and frame-memory reads.
// Ports:
//   clk_in  - clock
//   rst_n   - asynchronous active-low reset; every stage loads rst_val
//   en      - advance one stage (pixel tick)
//   rst_val - per-bit reset value
//   din     - input bundle
//   dout    - output of the last stage (registered)
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_val;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 Hz VGA raster timing from a single system clock.
// Optional feature macro: VGA_SYNC_DELAY_EN -- when defined, hsync/vsync/
// blank_n pass through a SYNC_DELAY-stage delay line advancing on the pixel
// tick; when undefined they are decoded from the counters and registered once.
// Ports:
//   clk_in      - system clock
//   rst_n       - asynchronous active-low reset
//   pix_tick    - one-cycle pixel strobe (held high when CLK_DIV = 1)
//   next_x      - horizontal counter, 0..H_TOTAL-1, unclipped
//   next_y      - vertical counter, 0..V_TOTAL-1, unclipped
//   hsync       - active-low horizontal sync
//   vsync       - active-low vertical sync
//   blank_n     - high inside the active area
//   frame_start - one-cycle pulse in the cycle the counters become (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    output logic               pix_tick,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n,
    output logic               frame_start
);

    localparam int H_TOTAL_L = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_L = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL_L - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL_L - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SS_C   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SE_C   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SS_C   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SE_C   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               pix_tick_q, pix_tick_d;
    logic               frame_start_q, frame_start_d;
    logic               tick;
    logic               h_wrap;
    logic               v_wrap;
    vga_ctrl_t          ctrl_now;
    vga_ctrl_t          ctrl_q;

    // The internal tick is the cycle the divider sits at its last value; the
    // counters step on the same edge that raises the registered pix_tick, so
    // next_x/next_y and pix_tick always change together.
    always_comb begin
        tick          = (div_q == DIV_LAST);
        h_wrap        = (h_cnt_q == H_LAST);
        v_wrap        = (v_cnt_q == V_LAST);
        div_d         = tick ? '0 : div_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end
        end
        pix_tick_d    = tick;
        // Only a real wrap produces the pulse; reset release leaves (0,0)
        // in place without one.
        frame_start_d = tick && h_wrap && v_wrap;
        ctrl_now      = decode_ctrl(h_cnt_q, v_cnt_q, H_ACT_C, H_SS_C, H_SE_C,
                                    V_ACT_C, V_SS_C, V_SE_C);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    // Stage 0 captures the decode of the counter value in place before the
    // tick, so the output reflects the counters SYNC_DELAY ticks earlier.
    logic [2:0] ctrl_dly;

    vga_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (tick),
        .rst_val (CTRL_RESET),
        .din     (ctrl_now),
        .dout    (ctrl_dly)
    );

    assign ctrl_q = vga_ctrl_t'(ctrl_dly);
`else
    vga_ctrl_t ctrl_d;

    always_comb begin
        ctrl_d = ctrl_now;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_RESET;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end
`endif

    assign pix_tick    = pix_tick_q;
    assign next_x      = h_cnt_q;
    assign next_y      = v_cnt_q;
    assign hsync       = ctrl_q.hsync;
    assign vsync       = ctrl_q.vsync;
    assign blank_n     = ctrl_q.blank_n;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing uses the real 640x480
// values; the vertical timing is shortened to 8 lines (4 active, 1 front
// porch, 2 sync, 1 back porch) so whole frames fit in a short run.
// With CLK_DIV = 2: line = 1600 cycles, frame = 800 * 8 * 2 = 12800 cycles,
// vsync low on lines 5 and 6.
module tb_vga_timing_gen;

    localparam int FRAME_CYC = 12800;

    logic       clk_in;
    logic       rst_n;
    logic       pix_tick;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int fs_count = 0;

    vga_timing_gen #(
        .H_ACTIVE   (640),
        .H_FP       (16),
        .H_SYNC     (96),
        .H_BP       (48),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .CLK_DIV    (2),
        .SYNC_DELAY (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .next_x      (next_x),
        .next_y      (next_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .frame_start (frame_start)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        cyc_cnt <= cyc_cnt + 1;
        // Sees the value held during the previous cycle, so each one-cycle
        // pulse is counted exactly once, one edge after it is visible.
        if (frame_start) fs_count <= fs_count + 1;
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_x"},     next_x,      0);
        check_val({tag, "_y"},     next_y,      0);
        check_val({tag, "_hsync"}, hsync,       1);
        check_val({tag, "_vsync"}, vsync,       1);
        check_val({tag, "_blank"}, blank_n,     0);
        check_val({tag, "_tick"},  pix_tick,    0);
        check_val({tag, "_fs"},    frame_start, 0);
    endtask

    // Wait (negedge sampling) until the counters show (x,y); timeout counts
    // as a failed comparison.
    task automatic wait_xy(input string tag, input int x, input int y, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk_in);
            if (next_x == x && next_y == y) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({tag, "_reached"}, int'(ok), 1);
    endtask

    task automatic wait_fs(input string tag, input int max_cyc, output int at_cyc);
        bit ok;
        ok = 1'b0;
        at_cyc = -1;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk_in);
            if (frame_start) begin
                ok = 1'b1;
                at_cyc = cyc_cnt;
                break;
            end
        end
        check_val({tag, "_seen"}, int'(ok), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_rel;
        int t_fs1;
        int t_fs2;
        int n_cyc;
        int low_cnt;
        int fs_before;

        // 1. reset values
        rst_n = 1'b0;
        repeat (5) @(negedge clk_in);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        t_rel = cyc_cnt;

        n_cyc = 0;
        do begin
            @(negedge clk_in);
            n_cyc++;
        end while (!pix_tick && n_cyc < 20);
        check_val("first_tick_cyc", n_cyc, 2);
        check_val("first_tick_x", next_x, 1);
        check_val("first_tick_blank", blank_n, 1);
        @(negedge clk_in);
        check_val("tick_one_cycle", pix_tick, 0);

        // 2. blank_n falls one clk after x reaches 640
        wait_xy("x640", 640, 0, 2000);
        check_val("blank_at_640_first", blank_n, 1);
        @(negedge clk_in);
        check_val("blank_at_640_next", blank_n, 0);

        // 3/5. hsync start and width
`ifdef VGA_SYNC_DELAY_EN
        wait_xy("x657", 657, 0, 100);
        check_val("hsync_before_fall", hsync, 1);
        wait_xy("x658", 658, 0, 100);
        check_val("hsync_fall_x658", hsync, 0);
`else
        wait_xy("x656", 656, 0, 100);
        check_val("hsync_at_656_first", hsync, 1);
        @(negedge clk_in);
        check_val("hsync_at_656_next", hsync, 0);
        check_val("hsync_fall_x", next_x, 656);
`endif
        low_cnt = 0;
        while (hsync == 1'b0 && low_cnt < 1000) begin
            low_cnt++;
            @(negedge clk_in);
        end
        check_val("hsync_low_cycles", low_cnt, 192);
`ifdef VGA_SYNC_DELAY_EN
        check_val("hsync_rise_x", next_x, 754);
`else
        check_val("hsync_rise_x", next_x, 752);
`endif

        // 2. line wrap
        wait_xy("x799", 799, 0, 400);
        repeat (2) @(negedge clk_in);
        check_val("wrap_x", next_x, 0);
        check_val("wrap_y", next_y, 1);

        // blank on last active line vs first blanked line
        wait_xy("x10y3", 10, 3, 5000);
        @(negedge clk_in);
        check_val("blank_line3", blank_n, 1);
        wait_xy("x10y4", 10, 4, 2000);
        @(negedge clk_in);
        check_val("blank_line4", blank_n, 0);

        // 3. vsync low only on lines 5 and 6
        wait_xy("x0y5", 0, 5, 2000);
        check_val("vsync_y5_first", vsync, 1);
        @(negedge clk_in);
        check_val("vsync_y5_next", vsync, 0);
        wait_xy("x700y6", 700, 6, 4000);
        check_val("vsync_y6", vsync, 0);
        wait_xy("x0y7", 0, 7, 1000);
        check_val("vsync_y7_first", vsync, 0);
        @(negedge clk_in);
        check_val("vsync_y7_next", vsync, 1);

        // 4. frame wrap and period
        wait_xy("x799y7", 799, 7, 2000);
        repeat (2) @(negedge clk_in);
        check_val("fwrap_x", next_x, 0);
        check_val("fwrap_y", next_y, 0);
        check_val("fwrap_fs", frame_start, 1);
        check_val("no_fs_before_first", fs_count, 0);
        t_fs1 = cyc_cnt;
        check_val("first_fs_after_release", t_fs1 - t_rel, FRAME_CYC);
        @(negedge clk_in);
        check_val("fs_one_cycle", frame_start, 0);
        wait_fs("fs2", FRAME_CYC + 200, t_fs2);
        check_val("frame_period", t_fs2 - t_fs1, FRAME_CYC);

        // 6. reset mid-frame (asynchronous, off the clock edge)
        wait_xy("x300y2", 300, 2, 5000);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk_in);
        check_reset_outputs("midrst_hold");
        fs_before = fs_count;
        rst_n = 1'b1;
        t_rel = cyc_cnt;
        wait_fs("fs_after_midrst", FRAME_CYC + 200, t_fs1);
        check_val("midrst_fs_delay", t_fs1 - t_rel, FRAME_CYC);
        check_val("midrst_no_release_pulse", fs_count, fs_before);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
